// File: rtl/pipe_pkg.sv
// Shared types and defaults for the valid/ready pipeline stage registers
// (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 64;
  localparam int BUBBLE_W   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  // Saturating increment for the bubble counter
  function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
    return (v == {BUBBLE_W{1'b1}}) ? v : v + {{(BUBBLE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control bundle and datapath bundle.
// Clearing invalidates the entry and zeroes control; data is kept.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end
  end

  // NOTE: the datapath flops are reset as well, since their reset value is
  // observable on out_data; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush, bubble-zeroed control and a saturating bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SKID_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   in_ctrl,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [DATA_W-1:0]   out_data,
  output logic [BUBBLE_W-1:0] bubble_cnt
);

  localparam bit USE_SKID = (SKID_EN != 0);

  stage_state_t        state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [BUBBLE_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              accept, drain;

  // in_ready_q is low in reset and in SKID; without skid it also gates the
  // combinational ready so nothing is accepted during reset.
  assign in_ready = USE_SKID ? in_ready_q
                             : (in_ready_q & (out_ready | ~main_valid));

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = MAIN;
          end
        end
        MAIN: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept && USE_SKID) begin
            skid_load = 1'b1;
            state_d   = SKID;
          end else if (drain) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        SKID: begin
          if (drain && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = MAIN;
          end else if (drain) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d   = (state_d != SKID);
    bubble_cnt_d = (!main_valid && out_ready) ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clear   (main_clear),
    .in_ctrl (main_ctrl_in),
    .in_data (main_data_in),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  assign out_valid  = main_valid;
  assign out_ctrl   = main_ctrl;
  assign out_data   = main_data;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-entry instance,
// each compared every cycle against a queue-based model of the stage.
module tb_pipe_stage_reg;

  typedef struct {
    logic [15:0] c;
    logic [63:0] d;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [2];
  logic        ordy [2];
  logic        fl   [2];
  logic [15:0] ic   [2];
  logic [63:0] id   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [15:0] oc   [2];
  logic [63:0] od   [2];
  logic [15:0] bc   [2];

  // Model state, index 1 = skid instance, index 0 = single-entry instance
  item_t       mq [2][$];
  logic [63:0] m_last [2];
  logic [15:0] m_bc   [2];
  bit          m_rdy;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(64), .SKID_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_ctrl(ic[1]), .in_data(id[1]), .flush(fl[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_ctrl(oc[1]), .out_data(od[1]), .bubble_cnt(bc[1])
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(64), .SKID_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_ctrl(ic[0]), .in_data(id[0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_ctrl(oc[0]), .out_data(od[0]), .bubble_cnt(bc[0])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Skid stage refuses only when holding two items; single stage refuses when full and stalled
  function automatic logic exp_rdy(input int m);
    if (!m_rdy) return 1'b0;
    if (m == 1) return mq[1].size() < 2;
    return ordy[0] || (mq[0].size() == 0);
  endfunction

  task automatic check_outputs(input int m);
    bit has = mq[m].size() > 0;
    string s = (m == 1) ? "skid" : "single";
    check({s, ".out_valid"},  64'(ov[m]), 64'(has));
    check({s, ".out_ctrl"},   64'(oc[m]), has ? 64'(mq[m][0].c) : 64'd0);
    check({s, ".out_data"},   od[m],      has ? mq[m][0].d : m_last[m]);
    check({s, ".in_ready"},   64'(ir[m]), 64'(exp_rdy(m)));
    check({s, ".bubble_cnt"}, 64'(bc[m]), 64'(m_bc[m]));
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_last[m] = '0;
      m_bc[m]   = '0;
    end
    m_rdy = 1'b0;
  endtask

  // One clock: check outputs after the inputs settle, advance the model, cross the posedge
  task automatic tick(input bit do_check = 1'b1);
    bit acc [2];
    bit drn [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      if (do_check) check_outputs(m);
      acc[m] = iv[m] && exp_rdy(m);
      drn[m] = (mq[m].size() > 0) && ordy[m];
    end
    for (int m = 0; m < 2; m++) begin
      if (mq[m].size() == 0 && ordy[m] && m_bc[m] != 16'hFFFF) m_bc[m]++;
      if (fl[m]) mq[m].delete();
      else begin
        if (drn[m]) void'(mq[m].pop_front());
        if (acc[m]) mq[m].push_back('{c: ic[m], d: id[m]});
      end
      if (mq[m].size() > 0) m_last[m] = mq[m][0].d;
    end
    m_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int m, input bit v, input logic [15:0] c, input logic [63:0] d,
                       input bit f, input bit r);
    iv[m] = v; ic[m] = c; id[m] = d; fl[m] = f; ordy[m] = r;
  endtask

  task automatic idle_all(input bit r);
    for (int m = 0; m < 2; m++) drive(m, 1'b0, 16'h0, 64'h0, 1'b0, r);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all(1'b0);
    model_reset();
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single item into an empty stage appears one cycle later
    for (int m = 0; m < 2; m++) drive(m, 1'b1, 16'h0003, 64'hA5, 1'b0, 1'b0);
    tick();
    idle_all(1'b0);
    check("lat1.out_ctrl", 64'(oc[1]), 64'h0003);
    check("lat1.out_data", od[1], 64'hA5);
    tick();

    // Skid instance: B into SKID with A stalled, then drain A then B
    drive(1, 1'b1, 16'h00B0, 64'hB0B0, 1'b0, 1'b0);
    tick();
    iv[1] = 1'b0;
    check("skid.in_ready_full", 64'(ir[1]), 64'd0);
    ordy[1] = 1'b1;
    ordy[0] = 1'b1;
    tick();
    check("skid.second_out", od[1], 64'hB0B0);
    check("skid.ready_after_A", 64'(ir[1]), 64'd1);
    tick();
    tick();

    // Flush while in SKID with a new item offered
    drive(1, 1'b1, 16'h0011, 64'h11, 1'b0, 1'b0);
    tick();
    drive(1, 1'b1, 16'h0022, 64'h22, 1'b0, 1'b0);
    tick();
    drive(1, 1'b1, 16'h0033, 64'h33, 1'b1, 1'b0);
    tick();
    idle_all(1'b1);
    check("flush.out_valid", 64'(ov[1]), 64'd0);
    check("flush.in_ready", 64'(ir[1]), 64'd1);
    for (int i = 0; i < 3; i++) tick();

    // Single-entry instance held stalled for five cycles
    drive(0, 1'b1, 16'h0C0C, 64'hC0FFEE, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 16'($urandom), {$urandom, $urandom}, 1'b0, 1'b0);
      tick();
      check("stall.single_data", od[0], 64'hC0FFEE);
    end

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        drive(m, $urandom_range(0, 3) != 0, 16'($urandom), {$urandom, $urandom},
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
      tick();
    end

    // Asynchronous reset mid-cycle while the skid instance holds two items
    idle_all(1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1, 1'b1, 16'h0100 + 16'(k), 64'h5000 + 64'(k), 1'b0, 1'b0);
      tick();
    end
    iv[1] = 1'b0;
    check("pre_rst.in_ready", 64'(ir[1]), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Bubble counting from reset, then saturation
    idle_all(1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("bubble10", 64'(bc[1]), 64'd10);
    for (int i = 0; i < 65530; i++) tick(1'b0);
    tick();
    tick();
    check("bubble_sat", 64'(bc[1]), 64'hFFFF);
    check("bubble_sat0", 64'(bc[0]), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
